// File: rtl/pal576i_line_counter_if.sv
// Sync pulses from the PAL 576i sync regenerator and the raster-position status
// produced by the line counter for capture/overlay logic.
interface pal576i_line_counter_if;
    logic        hsync_pulse;
    logic        vsync_pulse;
    logic        field_is_odd;
    logic [12:0] x_count;
    logic [8:0]  line_in_field;
    logic [9:0]  frame_line;
    logic        field_odd;
    logic        field_start;
    logic        active_video;
    logic        locked;

    modport master (
        output hsync_pulse, vsync_pulse, field_is_odd,
        input  x_count, line_in_field, frame_line, field_odd, field_start, active_video,
               locked
    );

    modport slave (
        input  hsync_pulse, vsync_pulse, field_is_odd,
        output x_count, line_in_field, frame_line, field_odd, field_start, active_video,
               locked
    );
endinterface

// File: rtl/pal576i_line_counter.sv
// Tracks PAL 576i raster position from regenerated sync pulses and derives the active-video
// window, a field-start pulse and a lock status.
module pal576i_line_counter #(
    parameter int unsigned CLK_PER_LINE    = 5184,
    parameter int unsigned ACTIVE_X_START  = 851,
    parameter int unsigned ACTIVE_WIDTH    = 4212,
    parameter int unsigned MAX_FIELD_LINES = 320,
    parameter int unsigned LOCK_FIELDS     = 2
) (
    input logic                   clk,
    input logic                   reset,
    pal576i_line_counter_if.slave sync
);

    localparam int unsigned XLossRaw = 2 * CLK_PER_LINE;
    // Two missing lines would overflow the 13-bit counter, so the loss limit caps at 8191.
    localparam logic [12:0] XLossLim = (XLossRaw > 8191) ? 13'h1fff : 13'(XLossRaw);
    localparam logic [12:0] XStart   = 13'(ACTIVE_X_START);
    localparam logic [12:0] XEnd     = 13'(ACTIVE_X_START + ACTIVE_WIDTH);
    localparam logic [8:0]  MaxLines = 9'(MAX_FIELD_LINES);
    localparam logic [3:0]  LockCnt  = 4'(LOCK_FIELDS);

    typedef enum logic [1:0] {StUnlocked, StAcquire, StLocked} state_e;

    state_e      state_q, state_d;
    logic [12:0] x_q;
    logic [8:0]  line_q, line_d;
    logic [9:0]  frame_q, frame_d, frame_sum;
    logic        odd_q, odd_d;
    logic        pend_q, vs_d1_q, par_next_q, prev_par_q;
    logic        fs_q, act_q, act_d;
    logic [3:0]  good_q, good_d, good_inc;
    logic        field_end, field_good, x_max, frame_in_window;

    assign field_end  = sync.hsync_pulse & pend_q;
    assign field_good = field_end && (line_q == 9'd312 || line_q == 9'd313) &&
                        (par_next_q != prev_par_q);
    assign x_max      = (x_q == 13'h1fff);
    assign good_inc   = good_q + 4'd1;

    always_comb begin
        line_d = line_q;
        odd_d  = odd_q;
        if (sync.hsync_pulse) begin
            if (pend_q) begin
                line_d = 9'd1;
                odd_d  = par_next_q;
            end else if (line_q != 9'h1ff) begin
                line_d = line_q + 9'd1;
            end
        end
        frame_sum = odd_d ? {1'b0, line_d} : {1'b0, line_d} + 10'd313;
        frame_d   = (frame_sum > 10'd625) ? 10'd625 : frame_sum;
    end

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        unique case (state_q)
            StUnlocked: begin
                if (sync.vsync_pulse) begin
                    good_d  = 4'd0;
                    state_d = StAcquire;
                end
            end
            StAcquire: begin
                if (field_end) begin
                    if (field_good) begin
                        good_d = good_inc;
                        if (good_inc >= LockCnt) state_d = StLocked;
                    end else begin
                        good_d = 4'd0;
                    end
                end
            end
            StLocked: begin
                if ((field_end && !field_good) || (line_q > MaxLines) || (x_q >= XLossLim)) begin
                    state_d = StUnlocked;
                end
            end
            default: state_d = StUnlocked;
        endcase
        if (x_max) state_d = StUnlocked;
    end

    always_comb begin
        frame_in_window = ((frame_q >= 10'd23) && (frame_q <= 10'd310)) ||
                          ((frame_q >= 10'd336) && (frame_q <= 10'd623));
        act_d = (state_q == StLocked) && (x_q >= XStart) && (x_q < XEnd) && frame_in_window;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StUnlocked;
            x_q        <= 13'd0;
            line_q     <= 9'd0;
            frame_q    <= 10'd0;
            odd_q      <= 1'b0;
            pend_q     <= 1'b0;
            vs_d1_q    <= 1'b0;
            par_next_q <= 1'b0;
            prev_par_q <= 1'b0;
            fs_q       <= 1'b0;
            act_q      <= 1'b0;
            good_q     <= 4'd0;
        end else begin
            if (sync.hsync_pulse) begin
                x_q <= 13'd0;
            end else if (!x_max) begin
                x_q <= x_q + 13'd1;
            end
            // A vsync coincident with hsync stays pending for the following line start.
            pend_q  <= sync.vsync_pulse | (pend_q & ~sync.hsync_pulse);
            vs_d1_q <= sync.vsync_pulse;
            if (vs_d1_q) par_next_q <= sync.field_is_odd;
            if (field_end) prev_par_q <= par_next_q;
            line_q <= line_d;
            odd_q  <= odd_d;
            if (sync.hsync_pulse) frame_q <= frame_d;
            fs_q    <= field_end;
            act_q   <= act_d;
            state_q <= state_d;
            good_q  <= good_d;
        end
    end

    assign sync.x_count       = x_q;
    assign sync.line_in_field = line_q;
    assign sync.frame_line    = frame_q;
    assign sync.field_odd     = odd_q;
    assign sync.field_start   = fs_q;
    assign sync.active_video  = act_q;
    assign sync.locked        = (state_q == StLocked);

endmodule

// File: tb/tb_pal576i_line_counter.sv
// Self-checking bench for pal576i_line_counter: short lines for speed, full-length lines
// where the active window is exercised, field-start and active runs scored from queues.
module tb_pal576i_line_counter;

    localparam int LongLen = 5184;
    localparam int ShortLen = 6;
    localparam int ActX0 = 851;
    localparam int ActW = 4212;

    typedef struct {int frame; int odd;} fs_t;
    typedef struct {int off; int wid;} act_t;

    logic clk;
    logic reset;
    pal576i_line_counter_if sif ();

    pal576i_line_counter dut (
        .clk  (clk),
        .reset(reset),
        .sync (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   hs_cyc = 0;
    int   rise_cyc = 0;
    int   act_runs = 0;
    bit   act_prev = 1'b0;
    fs_t  fs_q[$];
    act_t act_q[$];

    // Bench's own view of the raster
    int exp_line = 0;
    int exp_odd = 0;
    bit pend = 1'b0;
    bit pend_par = 1'b0;
    bit long_map[512];
    bit act_map[512];

    task automatic check_eq(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_frame();
        int f;
        f = (exp_odd != 0) ? exp_line : exp_line + 313;
        if (f > 625) f = 625;
        return f;
    endfunction

    task automatic do_line(input int len, input int vs_at, input bit par, input bit act_exp,
                           input int lock_exp);
        int   runs0;
        fs_t  f;
        act_t a;
        runs0 = act_runs;
        for (int i = 0; i < len; i++) begin
            sif.hsync_pulse  = (i == 0);
            sif.vsync_pulse  = (i == vs_at);
            sif.field_is_odd = (i == vs_at + 1) ? par : ~par;
            if (i == 0) begin
                if (pend) begin
                    exp_line = 1;
                    exp_odd  = int'(pend_par);
                    f.frame  = exp_frame();
                    f.odd    = exp_odd;
                    fs_q.push_back(f);
                end else if (exp_line < 511) begin
                    exp_line++;
                end
                pend = 1'b0;
                if (act_exp) begin
                    a.off = ActX0 + 1;
                    a.wid = ActW;
                    act_q.push_back(a);
                end
            end
            if (i == vs_at) begin
                pend     = 1'b1;
                pend_par = par;
            end
            tick();
            if (i == 0) begin
                check_eq("line_in_field", int'(sif.line_in_field), exp_line);
                check_eq("frame_line", int'(sif.frame_line), exp_frame());
                if (lock_exp >= 0) check_eq("locked_at_line", int'(sif.locked), lock_exp);
            end
        end
        sif.hsync_pulse = 1'b0;
        sif.vsync_pulse = 1'b0;
        if (len >= 1000) check_eq("active_runs", act_runs - runs0, int'(act_exp));
    endtask

    task automatic do_field(input int nlines, input bit next_par, input bit send_vs,
                            input int lock_exp);
        for (int ln = 1; ln <= nlines; ln++) begin
            do_line(long_map[ln] ? LongLen : ShortLen, (send_vs && ln == nlines) ? 2 : -1,
                    next_par, act_map[ln], (ln == 1) ? lock_exp : -1);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (sif.hsync_pulse) hs_cyc = cyc;
        end
    end

    initial begin
        fs_t  f;
        act_t a;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (sif.field_start) begin
                    check_eq("fs_queued", (fs_q.size() > 0) ? 1 : 0, 1);
                    if (fs_q.size() > 0) begin
                        f = fs_q.pop_front();
                        check_eq("fs_frame_line", int'(sif.frame_line), f.frame);
                        check_eq("fs_field_odd", int'(sif.field_odd), f.odd);
                        check_eq("fs_line_one", int'(sif.line_in_field), 1);
                    end
                end
                if (sif.active_video && !act_prev) rise_cyc = cyc;
                if (!sif.active_video && act_prev) begin
                    act_runs++;
                    check_eq("act_queued", (act_q.size() > 0) ? 1 : 0, 1);
                    if (act_q.size() > 0) begin
                        a = act_q.pop_front();
                        check_eq("act_offset", rise_cyc - hs_cyc, a.off);
                        check_eq("act_width", cyc - rise_cyc, a.wid);
                    end
                end
                act_prev = sif.active_video;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL timeout: run still active at %0t, limit 2ms", $time);
        $fatal(1, "timeout");
    end

    initial begin
        reset            = 1'b1;
        sif.hsync_pulse  = 1'b0;
        sif.vsync_pulse  = 1'b0;
        sif.field_is_odd = 1'b0;
        repeat (3) tick();
        check_eq("rst_locked", int'(sif.locked), 0);
        check_eq("rst_x_count", int'(sif.x_count), 0);
        reset = 1'b0;

        // A few lines without vsync, then reset asynchronously mid-line
        repeat (3) do_line(ShortLen, -1, 1'b0, 1'b0, 0);
        tick();
        #2 reset = 1'b1;
        #1;
        check_eq("midrst_x_count", int'(sif.x_count), 0);
        check_eq("midrst_line", int'(sif.line_in_field), 0);
        check_eq("midrst_frame", int'(sif.frame_line), 0);
        check_eq("midrst_field_odd", int'(sif.field_odd), 0);
        check_eq("midrst_field_start", int'(sif.field_start), 0);
        check_eq("midrst_active", int'(sif.active_video), 0);
        check_eq("midrst_locked", int'(sif.locked), 0);
        tick();
        reset    = 1'b0;
        exp_line = 0;
        exp_odd  = 0;
        pend     = 1'b0;
        repeat (20) tick();
        check_eq("idle_x_count", int'(sif.x_count), 20);
        check_eq("idle_line", int'(sif.line_in_field), 0);
        check_eq("idle_frame", int'(sif.frame_line), 0);
        check_eq("idle_locked", int'(sif.locked), 0);
        check_eq("idle_active", int'(sif.active_video), 0);

        // Lock-up on an ideal stream: locked from the third field start
        do_line(ShortLen, 2, 1'b1, 1'b0, 0);
        do_field(313, 1'b0, 1'b1, 0);
        do_field(312, 1'b1, 1'b1, 0);
        long_map[22] = 1'b1;
        long_map[23] = 1'b1;  act_map[23]  = 1'b1;
        long_map[310] = 1'b1; act_map[310] = 1'b1;
        long_map[311] = 1'b1;
        do_field(313, 1'b0, 1'b1, 1);
        for (int i = 0; i < 512; i++) begin
            long_map[i] = 1'b0;
            act_map[i]  = 1'b0;
        end
        long_map[22] = 1'b1;
        do_field(312, 1'b1, 1'b1, 1);
        long_map[22] = 1'b0;

        // Two odd fields in a row drop lock; two good fields regain it
        do_field(313, 1'b1, 1'b1, 1);
        check_eq("lock_before_bad", int'(sif.locked), 1);
        do_field(313, 1'b0, 1'b1, 0);
        do_field(312, 1'b1, 1'b1, 0);

        // vsync stops: lock holds through line 320, drops the cycle after line 321
        do_field(320, 1'b0, 1'b0, 1);
        check_eq("lock_line320", int'(sif.locked), 1);
        do_line(1, -1, 1'b0, 1'b0, 1);
        tick();
        check_eq("lock_after_321", int'(sif.locked), 0);

        // Relock, then let the frame line clamp at 625 in an overlong even field
        do_line(ShortLen, 2, 1'b0, 1'b0, 0);
        do_field(312, 1'b1, 1'b1, 0);
        do_field(313, 1'b0, 1'b1, 0);
        do_field(314, 1'b0, 1'b0, 1);

        // All sync stops: x_count saturates and lock drops the cycle after
        repeat (8185) tick();
        check_eq("xsat_x_8190", int'(sif.x_count), 8190);
        check_eq("xsat_lock_8190", int'(sif.locked), 1);
        tick();
        check_eq("xsat_x_8191", int'(sif.x_count), 8191);
        check_eq("xsat_lock_8191", int'(sif.locked), 1);
        tick();
        check_eq("xsat_x_hold", int'(sif.x_count), 8191);
        check_eq("xsat_lock_drop", int'(sif.locked), 0);

        // Coincident hsync/vsync: line counts on, restarts at the following hsync
        do_line(ShortLen, 0, 1'b1, 1'b0, 0);
        do_line(ShortLen, -1, 1'b1, 1'b0, 0);
        do_line(ShortLen, -1, 1'b1, 1'b0, 0);
        repeat (3) tick();

        check_eq("fs_q_drained", fs_q.size(), 0);
        check_eq("act_q_drained", act_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
